vector_irq_ctl: RTL and testbench

Vectored interrupt controller feeding the processor module's `virq` / `ivec` / `istb` / `iack` interrupt bus. It collects level requests from up to NREQ peripheral devices and raises a single request to the CPU. On the CPU's vector strobe it arbitrates one winner, returns that device's vector with an acknowledge, and pulses a per-device grant so the device can drop its request. It sits directly upstream of the LSI-11 processor board, between the peripheral set and the CPU interrupt inputs.

---
 rtl/vector_irq_ctl_pkg.sv | 13 +
 rtl/vector_irq_ctl_irq_prio_pick.sv | 29 ++
 rtl/vector_irq_ctl.sv | 111 +++++++++++
 tb/tb_vector_irq_ctl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_irq_ctl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state
// encoding and the default spurious vector.
package vector_irq_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } irq_state_t;

  localparam logic [15:0] DEF_SPUR_VEC = 16'o0;

endpackage

// File: rtl/vector_irq_ctl_irq_prio_pick.sv
// Combinational priority encoder: returns the first asserted request found
// when scanning upward from start, wrapping NREQ-1 to 0.
module irq_prio_pick #(
  parameter int NREQ = 8,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int j;

  // Scan from the far end so the candidate nearest to start is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(start) + k) % NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vector_irq_ctl.sv
// Vectored interrupt controller: collects level requests, raises virq and
// answers the CPU vector strobe. `VIRQ_ROUND_ROBIN_EN selects rotating priority.
module vector_irq_ctl
  import vector_irq_ctl_pkg::*;
#(
  parameter int          NREQ     = 8,
  parameter logic [15:0] SPUR_VEC = DEF_SPUR_VEC
) (
  input  logic               clk_p,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    irq_req,
  input  logic [NREQ*16-1:0] irq_vec,
  output logic [NREQ-1:0]    irq_gnt,
  output logic               virq,
  output logic [15:0]        ivec,
  input  logic               istb,
  output logic               iack,
  output irq_state_t         dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: istb rising (seen low in IDLE first) opens a transaction;
  // iack stays high with ivec stable until istb is sampled low, then both clear.
  irq_state_t      state;
  logic            armed;
  logic            start_txn;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_start;
  logic [15:0]     vec_sel;
  logic [NREQ-1:0] gnt_onehot;

  assign start_txn  = (state == ST_IDLE) && istb && armed;
  assign vec_sel    = irq_vec[16*int'(pick_idx) +: 16] & 16'hFFFC;
  assign gnt_onehot = NREQ'(1) << pick_idx;
  assign dbg_state  = state;

  irq_prio_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (irq_req),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef VIRQ_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Spurious strobes leave the rotation untouched.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (start_txn && pick_valid) begin
      rr_ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : IW'(pick_idx + 1'b1);
    end
  end

  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      armed   <= 1'b0;
      virq    <= 1'b0;
      ivec    <= '0;
      iack    <= 1'b0;
      irq_gnt <= '0;
    end else begin
      irq_gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (!istb) armed <= 1'b1;
          if (start_txn) begin
            state <= ST_GRANT;
            armed <= 1'b0;
            virq  <= 1'b0;
            if (pick_valid) begin
              ivec    <= vec_sel;
              irq_gnt <= gnt_onehot;
            end else begin
              ivec <= SPUR_VEC;
            end
          end else begin
            virq <= |irq_req;
          end
        end
        ST_GRANT: begin
          state <= ST_HOLD;
          iack  <= 1'b1;
        end
        ST_HOLD: begin
          if (!istb) begin
            state <= ST_IDLE;
            iack  <= 1'b0;
            ivec  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_irq_ctl.sv
// Bench for vector_irq_ctl: directed handshakes plus randomized transactions
// against a transaction-level reference model.
module tb_vector_irq_ctl;
  import vector_irq_ctl_pkg::*;

  localparam int          NREQ = 8;
  localparam logic [15:0] SPUR = 16'o0;

  logic               clk_p = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    irq_req;
  logic [NREQ*16-1:0] irq_vec;
  logic [NREQ-1:0]    irq_gnt;
  logic               virq;
  logic [15:0]        ivec;
  logic               istb;
  logic               iack;
  irq_state_t         dbg_state;

  logic [15:0] vec_tab [NREQ];
  logic [15:0] exp_q[$];
  int          m_ptr;
  int          n_checks;
  int          n_pass;

  vector_irq_ctl #(
    .NREQ     (NREQ),
    .SPUR_VEC (SPUR)
  ) dut (
    .clk_p     (clk_p),
    .rst_n     (rst_n),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_gnt   (irq_gnt),
    .virq      (virq),
    .ivec      (ivec),
    .istb      (istb),
    .iack      (iack),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic load_vecs();
    for (int i = 0; i < NREQ; i++) irq_vec[16*i +: 16] = vec_tab[i];
  endtask

  task automatic rand_vecs();
    for (int i = 0; i < NREQ; i++) vec_tab[i] = 16'($urandom_range(0, 65535));
    load_vecs();
  endtask

  // Reference: collect pending indices in ascending order, pick the first
  // one at or after the rotation pointer (or simply the first one).
  task automatic model_strobe(output logic [15:0] ev, output logic [NREQ-1:0] eg);
    int pend[$];
    int w;
    for (int i = 0; i < NREQ; i++) if (irq_req[i]) pend.push_back(i);
    eg = '0;
    if (pend.size() == 0) begin
      ev = SPUR;
    end else begin
      w = pend[0];
`ifdef VIRQ_ROUND_ROBIN_EN
      begin
        bit found = 1'b0;
        for (int k = 0; k < pend.size(); k++) begin
          if (!found && pend[k] >= m_ptr) begin
            w = pend[k];
            found = 1'b1;
          end
        end
      end
      m_ptr = (w + 1) % NREQ;
`endif
      ev = {vec_tab[w][15:2], 2'b00};
      eg[w] = 1'b1;
    end
  endtask

  // driver: one full strobe/acknowledge transaction starting from armed IDLE
  task automatic run_txn(input int hold_extra, input bit wiggle, input bit bounce);
    logic [15:0]     ev;
    logic [NREQ-1:0] eg;
    model_strobe(ev, eg);
    exp_q.push_back(ev);
    istb = 1'b1;
    tick();
    check_eq("grant_state", 32'(dbg_state), 32'(ST_GRANT));
    check_eq("grant_gnt", 32'(irq_gnt), 32'(eg));
    check_eq("grant_ivec", 32'(ivec), 32'(exp_q[0]));
    check_eq("grant_virq", 32'(virq), 32'd0);
    check_eq("grant_iack", 32'(iack), 32'd0);
    if (wiggle) irq_req = NREQ'($urandom);
    tick();
    check_eq("hold_iack", 32'(iack), 32'd1);
    check_eq("hold_gnt", 32'(irq_gnt), 32'd0);
    check_eq("hold_ivec", 32'(ivec), 32'(exp_q[0]));
    for (int h = 0; h < hold_extra; h++) begin
      tick();
      check_eq("hold_iack_stay", 32'(iack), 32'd1);
      check_eq("hold_ivec_stay", 32'(ivec), 32'(exp_q[0]));
      check_eq("hold_virq", 32'(virq), 32'd0);
    end
    istb = 1'b0;
    tick();
    check_eq("end_iack", 32'(iack), 32'd0);
    check_eq("end_ivec", 32'(ivec), 32'd0);
    check_eq("end_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("end_virq", 32'(virq), 32'd0);
    void'(exp_q.pop_front());
    if (bounce) begin
      istb = 1'b1;
      tick();
      check_eq("bounce_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("bounce_gnt", 32'(irq_gnt), 32'd0);
      check_eq("bounce_iack", 32'(iack), 32'd0);
      istb = 1'b0;
    end
    tick();
    check_eq("idle_virq", 32'(virq), 32'(|irq_req));
    check_eq("idle_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_ptr    = 0;
    rst_n    = 1'b0;
    istb     = 1'b0;
    irq_req  = '0;
    rand_vecs();
    #1;
    check_eq("rst_virq", 32'(virq), 32'd0);
    check_eq("rst_iack", 32'(iack), 32'd0);
    check_eq("rst_ivec", 32'(ivec), 32'd0);
    check_eq("rst_gnt", 32'(irq_gnt), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("quiet_virq", 32'(virq), 32'd0);
      check_eq("quiet_iack", 32'(iack), 32'd0);
      check_eq("quiet_ivec", 32'(ivec), 32'd0);
    end

    // single request on device 2
    vec_tab[2] = 16'o60;
    load_vecs();
    irq_req = 8'b0000_0100;
    tick();
    check_eq("req_virq", 32'(virq), 32'd1);
    tick();
    tick();
    run_txn(1, 1'b0, 1'b0);

    // low vector bits are masked
    vec_tab[1] = 16'o63;
    load_vecs();
    irq_req = 8'b0000_0010;
    tick();
    run_txn(0, 1'b0, 1'b0);

    // two back-to-back handshakes with devices 0 and 7 pending
    irq_req = 8'b1000_0001;
    tick();
    run_txn(0, 1'b0, 1'b1);
    run_txn(2, 1'b0, 1'b0);

    // request withdrawn before the strobe: spurious vector
    irq_req = 8'b0000_1000;
    tick();
    check_eq("spur_virq_up", 32'(virq), 32'd1);
    irq_req = '0;
    tick();
    check_eq("spur_virq_down", 32'(virq), 32'd0);
    run_txn(0, 1'b0, 1'b0);
    irq_req = 8'b1000_0001;
    tick();
    run_txn(0, 1'b0, 1'b0);

    // asynchronous reset while in HOLD
    irq_req = 8'b0010_0000;
    tick();
    istb = 1'b1;
    tick();
    tick();
    check_eq("pre_rst_iack", 32'(iack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_iack", 32'(iack), 32'd0);
    check_eq("async_ivec", 32'(ivec), 32'd0);
    check_eq("async_virq", 32'(virq), 32'd0);
    check_eq("async_state", 32'(dbg_state), 32'(ST_IDLE));
    istb  = 1'b0;
    m_ptr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_virq", 32'(virq), 32'd1);
    tick();
    run_txn(1, 1'b0, 1'b0);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      irq_req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) rand_vecs();
      tick();
      check_eq("rnd_virq", 32'(virq), 32'(|irq_req));
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
      run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
